// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute and a 4-lane byte-wide data memory with 1-cycle read latency.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic                  mem_we,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            lo_q, lo_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        legal;
  logic        misalign;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready = (state_q == IDLE) & rst_n;
  assign accept    = req_valid & req_ready;

  // Size/sign legality of the incoming request, plus optional alignment trap
  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
               ((req_funct3 == 3'b010) & (req_addr[1:0] != 2'b00));
`endif
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = ~misalign;
      3'b100, 3'b101:         legal = ~req_we & ~misalign;
      default:                legal = 1'b0;
    endcase
  end

  // Memory side: driven straight from the request in the accept cycle
  always_comb begin
    mem_addr  = accept ? req_addr[ADDR_WIDTH+1:2] : addr_q;
    mem_we    = accept & req_we & legal;
    mem_wmask = 4'b0000;
    mem_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        mem_wdata = {4{req_wdata[7:0]}};
        mem_wmask = 4'(4'b0001 << req_addr[1:0]);
      end
      2'b01: begin
        mem_wdata = {2{req_wdata[15:0]}};
        mem_wmask = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: mem_wmask = 4'b1111;
    endcase
    if (!mem_we) mem_wmask = 4'b0000;
  end

  // Lane extraction of the returned word using captured offset and size
  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state and registered response
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lo_d         = lo_q;
    funct3_d     = funct3_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = req_addr[ADDR_WIDTH+1:2];
          lo_d     = req_addr[1:0];
          funct3_d = req_funct3;
          if (!legal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_data;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lo_q         <= 2'd0;
      funct3_q     <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      funct3_q     <= funct3_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized traffic against a byte-array model, reset corner.
// Honours LSU_MISALIGN_TRAP_EN when the design is built with it.
module tb_load_store_unit;

  localparam int unsigned AW     = 12;
  localparam int unsigned NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_we;
  logic [3:0]    mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: byte lanes, registered read address
  logic [31:0]   dmem [0:(1<<AW)-1];
  logic [AW-1:0] raddr_q;
  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) dmem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    raddr_q <= mem_addr;
  end
  assign mem_rdata = dmem[raddr_q];

  // Reference: flat byte-addressed memory
  logic [7:0] ref_mem [0:NBYTES-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output logic [3:0] mask, output logic [31:0] mwd, output int lat);
    int unsigned n, ea;
    bit sgn, ok;
    n = 1; sgn = 1'b0; ok = 1'b1;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: begin n = 1; ok = !we; end
      3'd5: begin n = 2; ok = !we; end
      default: ok = 1'b0;
    endcase
    ea = addr & (NBYTES - 1);
`ifdef LSU_MISALIGN_TRAP_EN
    if (ea % n != 0) ok = 1'b0;
`else
    ea = ea - (ea % n);
`endif
    err = !ok; rd = 32'd0; mask = 4'd0; mwd = 32'd0; lat = 1;
    if (ok && we) begin
      for (int i = 0; i < int'(n); i++) begin
        ref_mem[ea + i] = wd[8*i +: 8];
        mask[(ea % 4) + i] = 1'b1;
      end
      for (int j = 0; j < 4; j++) mwd[8*j +: 8] = wd[8*(j % n) +: 8];
    end else if (ok) begin
      lat = 2;
      for (int i = 0; i < int'(n); i++) rd = rd | (32'(ref_mem[ea + i]) << (8*i));
      if (sgn && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
    end
  endtask

  // One request starting just after a falling edge; returns the observed response
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic got_err, output logic [31:0] got_rd);
    logic e_err; logic [31:0] e_rd, e_wd; logic [3:0] e_mask; int e_lat, lat;
    model(we, f3, addr, wd, e_err, e_rd, e_mask, e_wd, e_lat);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    chk("mem_we_accept", 32'(mem_we), 32'(we & !e_err));
    chk("mem_wmask", 32'(mem_wmask), 32'(e_mask));
    chk("mem_addr", 32'(mem_addr), 32'((addr & (NBYTES - 1)) >> 2));
    if (we && !e_err) chk("mem_wdata", mem_wdata, e_wd);
    @(negedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 4) begin
      chk("mem_we_idle", 32'(mem_we), 32'd0);
      @(negedge clk); #1;
      lat++;
    end
    got_err = resp_err; got_rd = resp_rdata;
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_err", 32'(resp_err), 32'(e_err));
    chk("resp_rdata", resp_rdata, e_rd);
    chk("ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("resp_pulse_end", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    logic g_err; logic [31:0] g_rd;
    vecs[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'b000, 32'h13,   32'h00000080, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b000, 32'h13,   32'h0,        1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1'b0, 3'b100, 32'h13,   32'h0,        1'b0, 32'h00000080};
    vecs[5]  = '{1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h80ADBEEF};
    vecs[6]  = '{1'b1, 3'b001, 32'h22,   32'h1234ABCD, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h22,   32'h0,        1'b0, 32'hFFFFABCD};
    vecs[8]  = '{1'b0, 3'b101, 32'h22,   32'h0,        1'b0, 32'h0000ABCD};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[9]  = '{1'b0, 3'b010, 32'h21,   32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b1, 3'b001, 32'h23,   32'h00005566, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 3'b101, 32'h22,   32'h0,        1'b0, 32'h0000ABCD};
`else
    vecs[9]  = '{1'b0, 3'b010, 32'h21,   32'h0,        1'b0, 32'hABCD0000};
    vecs[10] = '{1'b1, 3'b001, 32'h23,   32'h00005566, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 3'b101, 32'h22,   32'h0,        1'b0, 32'h00005566};
`endif
    vecs[12] = '{1'b1, 3'b100, 32'h10,   32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 3'b011, 32'h10,   32'h0,        1'b1, 32'h0};
    vecs[14] = '{1'b1, 3'b111, 32'h10,   32'h0,        1'b1, 32'h0};
    vecs[15] = '{1'b0, 3'b110, 32'h10,   32'h0,        1'b1, 32'h0};
    vecs[16] = '{1'b1, 3'b010, 32'h4010, 32'h11223344, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h11223344};

    for (int i = 0; i < (1 << AW); i++) dmem[i] = 32'd0;
    for (int i = 0; i < int'(NBYTES); i++) ref_mem[i] = 8'd0;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, g_err, g_rd);
      chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_rd);
    end

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_C03F;
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, g_err, g_rd);
    end

    // Reset during LOAD with a store held on the request port
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30;
    #1;
    chk("rl_accept_ready", 32'(req_ready), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b0; req_we = 1'b1; req_wdata = 32'hCAFEF00D;
    #1;
    chk("rl_ready_in_rst", 32'(req_ready), 32'd0);
    chk("rl_we_in_rst", 32'(mem_we), 32'd0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("rl_no_resp", 32'(resp_valid), 32'd0);
      chk("rl_ready_held", 32'(req_ready), 32'd0);
      chk("rl_no_write", 32'(mem_we), 32'd0);
    end
    req_valid = 1'b0; rst_n = 1'b1;
    #1;
    chk("rl_ready_release", 32'(req_ready), 32'd1);
    chk("rl_resp_release", 32'(resp_valid), 32'd0);
    @(negedge clk); #1;
    chk("rl_no_late_resp", 32'(resp_valid), 32'd0);
    do_req(1'b0, 3'b010, 32'h30, 32'd0, g_err, g_rd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the byte-lane data memory (4 byte-wide banks, word-indexed address, registered read address, 1-cycle read latency).
- Converts RV32I byte-addressed load/store requests (funct3-encoded size) into a word address, byte write mask and lane-replicated write data.
- Sequences the memory's read latency and returns aligned, sign- or zero-extended load data to the CPU through a valid/ready request and valid-only response handshake.

Parameters:
ADDR_WIDTH, 12, word-address width of the data memory; mem_addr = req_addr[ADDR_WIDTH+1:2]

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  CPU presents a load/store request
req_ready  output  1  unit can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (size/sign)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  request rejected (misaligned or illegal funct3); qualified by resp_valid
resp_rdata  output  32  load result; 0 for stores and errors
mem_we  output  1  memory write enable
mem_wmask  output  4  byte-lane write mask
mem_addr  output  ADDR_WIDTH  memory word address
mem_wdata  output  32  lane-replicated write data
mem_rdata  input  32  memory read data, valid the cycle after the address is sampled

Behaviour:
- Reset: synchronous; while rst_n=0 at a rising edge, state goes to IDLE and resp_valid, resp_err, resp_rdata and the captured request fields are cleared. req_ready=0 and mem_we=0 while rst_n=0.
- FSM states: IDLE, LOAD, RESP. req_ready = (state==IDLE) & rst_n. A request is accepted on req_valid & req_ready.
- Accept cycle (T): mem_addr, mem_we, mem_wmask and mem_wdata are driven combinationally from the req_* inputs. mem_we = accept & req_we & legal. In all other cycles mem_we=0 and mem_addr holds the captured address.
- Legal funct3: 000 B, 001 H, 010 W; loads also accept 100 BU and 101 HU.
  - Any other code (stores with 1xx; 011, 110, 111): no memory write, resp_err=1.
- Store lanes:
  - SB: mem_wdata={4{wdata[7:0]}}, mask=4'b0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mask=addr[1]?4'b1100:4'b0011.
  - SW: mem_wdata=wdata, mask=4'b1111.
  - Loads drive mask=0.
- Transitions:
  - Legal store: IDLE->RESP; write occurs at the T edge; resp_valid in T+1.
  - Legal load: IDLE->LOAD->RESP. mem_rdata is valid in T+1 and is extracted and registered at the end of T+1; resp_valid in T+2.
  - Error: IDLE->RESP; resp_valid=1 and resp_err=1 in T+1.
  - RESP->IDLE unconditionally. Throughput: store or error every 2 cycles, load every 3.
- Load extraction: the byte is selected by addr[1:0] and the halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
  - addr[1:0] and funct3 are captured at accept.
- Outputs resp_valid, resp_err and resp_rdata are registered. resp_rdata=0 unless the response is a successful load. There is no response backpressure.
- Reset mid-operation: the pending response is dropped. A store whose mem_we already pulsed stays written.
- req_* inputs are ignored outside IDLE.
- Address bits above ADDR_WIDTH+1 are ignored (wrap-around).

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 is an error.
  - No memory write; resp_err=1 in T+1 via IDLE->RESP.
- Undefined: misalignment is never an error; the offending low bits are forced to 0.
  - H uses addr[1] only; W uses lane 0. The access proceeds normally.
  - resp_err is then raised only for illegal funct3.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> mem_we pulse with mask=1111, mem_addr=4; load resp_valid at T+2 with rdata=0xDEADBEEF, err=0.
- SB 0x13 data=0x80, then LB 0x13 and LBU 0x13 -> mask=1000, mem_wdata=0x80808080; LB returns 0xFFFFFF80, LBU returns 0x00000080, other bytes of the word unchanged.
- SH 0x22 data=0x1234ABCD, then LH 0x22 -> mask=1100; returns 0xFFFFABCD; LHU returns 0x0000ABCD.
- LW 0x21:
  - With LSU_MISALIGN_TRAP_EN: resp_err=1, rdata=0, no read/write side effect.
  - Without: returns the word at 0x20.
- Store with funct3=100 -> mem_we never asserted, resp_valid=1 and resp_err=1 at T+1; req_ready back high at T+2.
- Reset mid-operation: assert rst_n=0 in the LOAD state -> no resp_valid; req_ready=0 during reset, 1 the cycle after release; a held req_valid is not accepted during reset.
